// File: rtl/seg_sched.sv
// seg_sched: shares one 8-digit 74HC595-driven hex display between four
// requesters. Each requester writes a 32-bit value into a shadow register;
// the value currently shown is the owner's working buffer.
//
// Ports
//   clk        single clock, all logic on posedge
//   rst        synchronous active-high reset
//   req_valid  per-requester data valid (4)
//   req_data   4 x 32-bit values, requester i at [32i+31:32i]
//   req_ready  per-requester ready, low while a written value is pending
//   auto_mode  1 = round-robin ownership every DWELL frames, 0 = key-stepped
//   key        raw asynchronous pushbutton
//   ds         595 serial data
//   shclk      595 shift clock
//   stclk      595 storage latch
//   owner      requester currently displayed
//   blank      high until any requester has loaded a value
//
// State  | meaning
// IDLE   | one cycle after reset release, before the first frame
// SHIFT  | shifting the 16-bit {sel, seg} word, 2 cycles per bit
// LATCH  | one-cycle storage latch pulse at the end of each digit

module seg_sched #(
  parameter int DWELL = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_valid,
  input  logic [127:0] req_data,
  output logic [3:0]   req_ready,
  input  logic         auto_mode,
  input  logic         key,
  output logic         ds,
  output logic         shclk,
  output logic         stclk,
  output logic [1:0]   owner,
  output logic         blank
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t      state;
  logic [2:0]  digit;
  logic [3:0]  bit_idx;
  logic        phase;

  logic [31:0] shadow [4];
  logic [3:0]  pending;
  logic [3:0]  loaded;
  logic [31:0] buffer;
  logic [15:0] count;
  logic        step;
  logic        key_s1, key_s2, key_s3;

  // active-low seven-segment pattern, bit 0 = decimal point
  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'h03;  4'h1: s = 8'h9F;  4'h2: s = 8'h25;  4'h3: s = 8'h0D;
      4'h4: s = 8'h99;  4'h5: s = 8'h49;  4'h6: s = 8'h41;  4'h7: s = 8'h1F;
      4'h8: s = 8'h01;  4'h9: s = 8'h09;  4'hA: s = 8'h11;  4'hB: s = 8'hC1;
      4'hC: s = 8'h63;  4'hD: s = 8'h85;  4'hE: s = 8'h61;  default: s = 8'h71;
    endcase
    return s;
  endfunction

  // {found, index} of the next loaded requester after cur, wrapping 3->0
  function automatic logic [2:0] next_loaded(input logic [1:0] cur,
                                             input logic [3:0] ld);
    logic [2:0] r;
    logic [1:0] idx;
    r = {1'b0, cur};
    for (int k = 1; k < 4; k++) begin
      idx = cur + 2'(k);
      if (ld[idx] && !r[2]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign req_ready = ~pending;

  logic       key_edge;
  logic [3:0] acc;
  assign key_edge = key_s2 & ~key_s3;
  assign acc      = req_valid & ~pending;

  // ---------------- frame boundary decision ----------------
  // The boundary is the first SHIFT cycle of digit 0, so the decision is
  // made on the cycle that transitions into it and registered on that edge.
  logic        at_bnd, frame_done;
  logic [2:0]  nl;
  logic [1:0]  lowest;
  logic [16:0] count_inc;
  logic [1:0]  bnd_owner;
  logic        bnd_change, bnd_blank;
  logic [15:0] bnd_count;
  logic [31:0] bnd_buf;
  logic [3:0]  bnd_clr;

  assign frame_done = (state == LATCH) && (digit == 3'd7);
  assign at_bnd     = (state == IDLE) || frame_done;
  assign nl         = next_loaded(owner, loaded);
  assign count_inc  = {1'b0, count} + 17'd1;

  always_comb begin
    lowest = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (loaded[i]) lowest = 2'(i);
  end

  always_comb begin
    bnd_owner  = owner;
    bnd_change = 1'b0;
    bnd_blank  = blank;
    bnd_count  = count;
    bnd_buf    = buffer;
    bnd_clr    = 4'b0000;
    if (blank) begin
      bnd_count = 16'd0;
      if (|loaded) begin
        bnd_owner  = lowest;
        bnd_change = 1'b1;
        bnd_blank  = 1'b0;
      end
    end else if (auto_mode) begin
      if (frame_done) begin
        if (count_inc >= 17'(DWELL)) begin
          // with no other loaded requester the count is left where it is,
          // so the advance is retried at every following frame
          if (nl[2]) begin
            bnd_owner  = nl[1:0];
            bnd_change = 1'b1;
            bnd_count  = 16'd0;
          end
        end else begin
          bnd_count = count_inc[15:0];
        end
      end
    end else begin
      bnd_count = 16'd0;
      if (step && nl[2]) begin
        bnd_owner  = nl[1:0];
        bnd_change = 1'b1;
      end
    end

    if (bnd_change) begin
      bnd_buf            = shadow[bnd_owner];
      bnd_clr[bnd_owner] = 1'b1;
    end else if (!bnd_blank && pending[owner]) begin
      bnd_buf        = shadow[owner];
      bnd_clr[owner] = 1'b1;
    end
  end

  // ---------------- shift sequencing ----------------
  state_t      st_n;
  logic [2:0]  digit_n;
  logic [3:0]  bit_n;
  logic        phase_n;
  logic [31:0] buf_eff;
  logic        blank_eff;
  logic [2:0]  nib_idx;
  logic [3:0]  nib_val;
  logic [15:0] word_n;

  always_comb begin
    st_n    = state;
    digit_n = digit;
    bit_n   = bit_idx;
    phase_n = phase;
    case (state)
      IDLE: begin
        st_n    = SHIFT;
        digit_n = 3'd0;
        bit_n   = 4'd0;
        phase_n = 1'b0;
      end
      SHIFT: begin
        if (!phase) begin
          phase_n = 1'b1;
        end else begin
          phase_n = 1'b0;
          if (bit_idx == 4'd15) st_n = LATCH;
          else                  bit_n = bit_idx + 4'd1;
        end
      end
      LATCH: begin
        st_n    = SHIFT;
        digit_n = digit + 3'd1;
        bit_n   = 4'd0;
        phase_n = 1'b0;
      end
      default: st_n = IDLE;
    endcase
  end

  // digit 0 of a new frame must already show the post-boundary buffer
  assign buf_eff   = at_bnd ? bnd_buf   : buffer;
  assign blank_eff = at_bnd ? bnd_blank : blank;
  assign nib_idx   = 3'd7 - digit_n;
  assign nib_val   = buf_eff[{nib_idx, 2'b00} +: 4];
  assign word_n    = blank_eff ? 16'h00FF : {8'h80 >> digit_n, hex_seg(nib_val)};

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      digit   <= 3'd0;
      bit_idx <= 4'd0;
      phase   <= 1'b0;
      ds      <= 1'b0;
      shclk   <= 1'b0;
      stclk   <= 1'b0;
      owner   <= 2'd0;
      blank   <= 1'b1;
      pending <= 4'b0000;
      loaded  <= 4'b0000;
      buffer  <= 32'd0;
      count   <= 16'd0;
      step    <= 1'b0;
      key_s1  <= 1'b0;
      key_s2  <= 1'b0;
      key_s3  <= 1'b0;
      for (int i = 0; i < 4; i++) shadow[i] <= 32'd0;
    end else begin
      state   <= st_n;
      digit   <= digit_n;
      bit_idx <= bit_n;
      phase   <= phase_n;

      case (st_n)
        SHIFT: begin
          stclk <= 1'b0;
          if (!phase_n) begin
            ds    <= word_n[4'd15 - bit_n];
            shclk <= 1'b0;
          end else begin
            shclk <= 1'b1;
          end
        end
        LATCH: begin
          shclk <= 1'b0;
          stclk <= 1'b1;
        end
        default: begin
          shclk <= 1'b0;
          stclk <= 1'b0;
        end
      endcase

      key_s1 <= key;
      key_s2 <= key_s1;
      key_s3 <= key_s2;

      // the boundary consumes the flag; an edge on that same cycle re-arms it
      if (!auto_mode) step <= (step & ~at_bnd) | key_edge;
      else            step <= 1'b0;

      if (at_bnd) begin
        owner  <= bnd_owner;
        blank  <= bnd_blank;
        buffer <= bnd_buf;
      end

      if (!auto_mode)  count <= 16'd0;
      else if (at_bnd) count <= bnd_count;

      pending <= (pending & ~(at_bnd ? bnd_clr : 4'b0000)) | acc;
      loaded  <= loaded | acc;
      for (int i = 0; i < 4; i++)
        if (acc[i]) shadow[i] <= req_data[32*i +: 32];
    end
  end

endmodule

// File: doc/seg_sched.md
SEG_SCHED -- requirements
Module: seg_sched

Interface
REQ-001 SHALL have parameter DWELL, default 256, meaning completed 8-digit frames per owner in auto mode (range 1..65535).
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  4  per-requester data valid.
REQ-005 SHALL have port req_data  input  128  4x32-bit hex value; requester i at [32i+31:32i]; nibble 7 leftmost.
REQ-006 SHALL have port req_ready  output  4  per-requester ready; req_ready[i] = !pending[i].
REQ-007 SHALL have port auto_mode  input  1  1 = round-robin rotation, 0 = key-driven.
REQ-008 SHALL have port key  input  1  raw pushbutton, asynchronous.
REQ-009 SHALL have port ds  output  1  74HC595 serial data.
REQ-010 SHALL have port shclk  output  1  595 shift clock.
REQ-011 SHALL have port stclk  output  1  595 storage latch.
REQ-012 SHALL have port owner  output  2  requester currently displayed.
REQ-013 SHALL have port blank  output  1  high when no requester has ever loaded.

Function
REQ-014 SHALL accept requester i when req_valid[i] & req_ready[i]: shadow[i] <= data, pending[i] <= 1, loaded[i] <= 1.
REQ-015 SHALL emit per digit a 16-bit word {sel, seg}, MSB first; sel = 8'h80 >> d, seg = hex table of nibble (7-d) of working buffer, d = digit 0..7.
REQ-016 SHALL use active-low table 0..F = 03,9F,25,0D,99,49,41,1F,01,09,11,C1,63,85,61,71.
REQ-017 SHALL output word 16'h00FF for every digit while blank = 1.
REQ-018 SHALL run FSM IDLE -> SHIFT -> LATCH -> SHIFT ...; IDLE lasts exactly one cycle after reset release.
REQ-019 SHALL take 2 cycles per bit in SHIFT: phase 0 ds = bit, shclk = 0; phase 1 ds held, shclk = 1; 16 bits = 32 cycles.
REQ-020 SHALL hold LATCH 1 cycle with stclk = 1, shclk = 0; stclk = 0 in every other state; digit period = 33 cycles, frame = 264 cycles.
REQ-021 SHALL treat first SHIFT cycle of digit 0 as the frame boundary; owner change and buffer snapshot occur only there.
REQ-022 SHALL at a boundary without owner change, if pending[owner], copy shadow[owner] into working buffer and clear pending[owner]; otherwise keep buffer.
REQ-023 SHALL in auto mode count completed frames; when count reaches DWELL, advance owner to next loaded index (wrapping 3->0, skipping unloaded), reset count to 0.
REQ-024 SHALL at an owner change always load shadow[new owner] into working buffer and clear pending[new owner].
REQ-025 SHALL keep owner and frame count unchanged if the only loaded requester is the current owner.
REQ-026 SHALL synchronise key through two flops and detect rising edges; in manual mode an edge sets a step flag consumed at the next boundary; multiple edges before one boundary = one step.
REQ-027 SHALL ignore key edges and discard step flag in auto mode; frame count held 0 in manual mode.
REQ-028 SHALL, on first-ever load while blank = 1, make that requester owner at the next boundary (lowest index on simultaneous loads) and clear blank.
REQ-029 SHALL never change owner or buffer mid-frame; auto_mode changes take effect at next boundary.

Reset
REQ-030 SHALL on rst: ds = 0, shclk = 0, stclk = 0, owner = 0, blank = 1, req_ready = 4'hF, pending/loaded/shadows/buffer/counters/step flag = 0, FSM = IDLE.
REQ-031 SHALL abort any in-progress shift immediately on rst, with the above values in the cycle after rst is sampled.

Verification
REQ-032 SHALL cover: reset, no loads -> every word 16'h00FF (sel=80..01 with seg FF? no: word 00FF), stclk every 33 cycles, blank = 1.
REQ-033 SHALL cover: load req 2 = 32'h01234567 -> owner = 2 next boundary; digit 0 word 16'h8003, digit 7 word 16'h011F; req_ready[2] low until that boundary.
REQ-034 SHALL cover: auto, DWELL = 2, reqs 0 and 3 loaded -> owner alternates 0,3,0 every 2 frames (528 cycles).
REQ-035 SHALL cover: manual, reqs 0,1,2 loaded, three key pulses within one frame -> owner advances by exactly 1.
REQ-036 SHALL cover: rst asserted at bit 9 of digit 4 -> next cycle ds = shclk = stclk = 0, req_ready = F, blank = 1.
